// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared constants and segment decoder for the BCD counter display
// Contents:
//   SEG_BLANK        all segments off (active-low {dp,g,f,e,d,c,b,a})
//   SEG_DIGIT[0..9]  active-low segment patterns for decimal digits, dp off
//   BCD_MAX          largest legal BCD digit
//   seg_of()         segment pattern for one BCD digit (blank for non-BCD codes)
package bcd_display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0,  // 0
        8'hF9,  // 1
        8'hA4,  // 2
        8'hB0,  // 3
        8'h99,  // 4
        8'h92,  // 5
        8'h82,  // 6
        8'hF8,  // 7
        8'h80,  // 8
        8'h90   // 9
    };

    function automatic logic [7:0] seg_of(input logic [3:0] digit);
        logic [7:0] pattern;
        pattern = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                pattern = SEG_DIGIT[i];
            end
        end
        return pattern;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser, debouncer and press-pulse generator
// Optional feature macro: BCD_COUNTER_AUTO_REPEAT_EN (auto-repeat while held).
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   btn    raw button level, active-high, asynchronous to clk
//   press  single-cycle registered pulse on each accepted press (and each repeat)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] db_cnt;
    logic          accept;
    logic          press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // accept fires on the DEBOUNCE_CYCLES-th consecutive cycle in which the
    // synchronised level disagrees with the accepted level
    assign accept = (sync_2 != level) && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync_2 == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            level  <= sync_2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

`ifdef BCD_COUNTER_AUTO_REPEAT_EN
    localparam int REPEAT_DELAY = 16 * DEBOUNCE_CYCLES;
    localparam int REPEAT_RATE  = 4 * DEBOUNCE_CYCLES;
    localparam int RW           = $clog2(REPEAT_DELAY);

    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic          rep_fire;

    // first repeat waits the long delay, later ones the shorter rate
    assign rep_fire = level && !accept &&
                      (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (!level || accept) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign press_d = (accept && !level) || rep_fire;
`else
    // only an accepted released->pressed change produces a pulse
    assign press_d = accept && !level;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= 1'b0;
        end else begin
            press <= press_d;
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with multiplexed seven-segment display
// Optional feature macro: BCD_COUNTER_AUTO_REPEAT_EN (passed through to key_debounce).
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   plus     increment button, active-high, asynchronous
//   min      decrement button, active-high, asynchronous
//   clr      synchronous clear of the count
//   value    packed BCD count, digit 0 in bits [3:0]
//   sm_wei   active-low one-hot digit enables
//   sm_duan  active-low segments {dp,g,f,e,d,c,b,a}
module bcd_counter_display
    import bcd_display_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plus,
    input  logic                min,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   sm_wei,
    output logic [7:0]          sm_duan
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    logic                plus_p;
    logic                min_p;
    logic [4*DIGITS-1:0] value_inc;
    logic [4*DIGITS-1:0] value_dec;
    logic                carry;
    logic                borrow;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_plus (
        .clk   (clk),
        .rst   (rst),
        .btn   (plus),
        .press (plus_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min (
        .clk   (clk),
        .rst   (rst),
        .btn   (min),
        .press (min_p)
    );

    // ripple carry/borrow through the digits; all-nines and all-zeros wrap naturally
    always_comb begin
        value_inc = value;
        value_dec = value;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] >= BCD_MAX) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    value_dec[4*i +: 4] = BCD_MAX;
                end else begin
                    value_dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (plus_p && !min_p) begin
            value <= value_inc;
        end else if (min_p && !plus_p) begin
            value <= value_dec;
        end
    end

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [IW-1:0]     show_idx;
    logic              tick;
    logic              lit;
    logic [3:0]        sel_digit;
    logic [DIGITS-1:0] wei_nxt;

    assign tick     = (presc == PW'(SCAN_DIV - 1));
    assign idx_nxt  = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    // on a tick the outputs load the digit being moved to, so enables and
    // segments always switch together
    assign show_idx = tick ? idx_nxt : idx;

    always_comb begin
        sel_digit = 4'd0;
        wei_nxt   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (show_idx == IW'(i)) begin
                sel_digit  = value[4*i +: 4];
                wei_nxt[i] = 1'b0;
            end
        end
    end

    // the display stays dark from reset until the first scan tick; after
    // that the current digit's segments are refreshed every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            idx     <= '0;
            lit     <= 1'b0;
            sm_wei  <= '1;
            sm_duan <= SEG_BLANK;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= idx_nxt;
                lit <= 1'b1;
            end
            if (tick || lit) begin
                sm_wei  <= wei_nxt;
                sm_duan <= seg_of(sel_digit);
            end
        end
    end

endmodule
